// File: rtl/texture_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : texture_fetch_ctrl_if
//  Brief    : Bundles the request FIFO, response FIFO and Avalon-MM read
//             signals of the texture fetch back-end.
//  Revision : 1.0
// ============================================================================
interface texture_fetch_ctrl_if;
  logic        FF_texture_empty;
  logic        FF_texture_readrequest;
  logic [31:0] FF_texture_q;
  logic        FF_rgb_almostfull;
  logic        FF_rgb_writerequest;
  logic [31:0] FF_rgb_data;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    input  FF_texture_empty, FF_texture_q, FF_rgb_almostfull,
           avm_waitrequest, avm_readdata, avm_readdatavalid,
    output FF_texture_readrequest, FF_rgb_writerequest, FF_rgb_data,
           avm_address, avm_read
  );

  modport slave (
    output FF_texture_empty, FF_texture_q, FF_rgb_almostfull,
           avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  FF_texture_readrequest, FF_rgb_writerequest, FF_rgb_data,
           avm_address, avm_read
  );
endinterface
`default_nettype wire

// File: rtl/texture_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : texture_fetch_ctrl
//  Brief    : Pops texel requests, issues pipelined Avalon reads and writes
//             {data, core_id} pairs to the RGB FIFO in request order.
//             Optional macro TEXFETCH_PERF_EN adds request/stall counters.
//  Revision : 1.0
// ============================================================================
module texture_fetch_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_SHIFT      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [31:0]                 tex_base_addr,
  texture_fetch_ctrl_if.master        bus,
  output logic                        busy,
  output logic                        err_unexpected
`ifdef TEXFETCH_PERF_EN
  ,
  output logic [31:0]                 perf_req_count,
  output logic [31:0]                 perf_stall_count
`endif
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {I_IDLE  = 1'b0, I_ISSUE = 1'b1} istate_t;
  typedef enum logic [1:0] {W_IDLE  = 2'd0, W_DATA  = 2'd1, W_ID = 2'd2} wstate_t;

  istate_t       istate_q, istate_d;
  wstate_t       wstate_q, wstate_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [31:0]   addr_q,   addr_d;
  logic          err_q,    err_d;

  logic [6:0]    tag_mem_q [MAX_OUTSTANDING];
  logic [6:0]    tag_mem_d [MAX_OUTSTANDING];
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0] tag_cnt_q, tag_cnt_d;

  // Response entry: {readdata[31:0], core_id[6:0]}
  logic [38:0]   rsp_mem_q [MAX_OUTSTANDING];
  logic [38:0]   rsp_mem_d [MAX_OUTSTANDING];
  logic [PW-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;

  logic          pop;
  logic          tag_empty;
  logic          rsp_push;
  logic          id_wr;
  logic [38:0]   rsp_head;
  logic          unused_q_msb;

  assign unused_q_msb = bus.FF_texture_q[31];

  always_comb begin
    istate_d                   = istate_q;
    addr_d                     = addr_q;
    pop                        = 1'b0;
    bus.FF_texture_readrequest = 1'b0;
    bus.avm_read               = 1'b0;
    bus.avm_address            = 32'd0;
    case (istate_q)
      I_IDLE: begin
        if (enable && !bus.FF_texture_empty && (credit_q < CW'(MAX_OUTSTANDING))) begin
          pop                        = 1'b1;
          bus.FF_texture_readrequest = 1'b1;
          addr_d   = tex_base_addr + ({8'd0, bus.FF_texture_q[23:0]} << ADDR_SHIFT);
          istate_d = I_ISSUE;
        end
      end
      I_ISSUE: begin
        bus.avm_read    = 1'b1;
        bus.avm_address = addr_q;
        if (!bus.avm_waitrequest) istate_d = I_IDLE;
      end
      default: istate_d = I_IDLE;
    endcase
  end

  // Tag FIFO: core_id of every popped request, consumed by returning data.
  always_comb begin
    tag_empty = (tag_cnt_q == '0);
    rsp_push  = bus.avm_readdatavalid && !tag_empty;
    err_d     = err_q | (bus.avm_readdatavalid && tag_empty);
    tag_mem_d = tag_mem_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    if (pop) begin
      tag_mem_d[tag_wr_q] = bus.FF_texture_q[30:24];
      tag_wr_d            = tag_wr_q + PW'(1);
    end
    if (rsp_push) tag_rd_d = tag_rd_q + PW'(1);
    tag_cnt_d = tag_cnt_q + CW'(pop) - CW'(rsp_push);
  end

  always_comb begin
    rsp_mem_d = rsp_mem_q;
    rsp_wr_d  = rsp_wr_q;
    rsp_rd_d  = rsp_rd_q;
    if (rsp_push) begin
      rsp_mem_d[rsp_wr_q] = {bus.avm_readdata, tag_mem_q[tag_rd_q]};
      rsp_wr_d            = rsp_wr_q + PW'(1);
    end
    if (id_wr) rsp_rd_d = rsp_rd_q + PW'(1);
    rsp_cnt_d = rsp_cnt_q + CW'(rsp_push) - CW'(id_wr);
    credit_d  = credit_q + CW'(pop) - CW'(id_wr);
  end

  always_comb begin
    wstate_d                = wstate_q;
    id_wr                   = 1'b0;
    bus.FF_rgb_writerequest = 1'b0;
    bus.FF_rgb_data         = 32'd0;
    rsp_head                = rsp_mem_q[rsp_rd_q];
    case (wstate_q)
      W_IDLE: begin
        if (rsp_cnt_q != '0) wstate_d = W_DATA;
      end
      W_DATA: begin
        bus.FF_rgb_data         = rsp_head[38:7];
        bus.FF_rgb_writerequest = !bus.FF_rgb_almostfull;
        if (!bus.FF_rgb_almostfull) wstate_d = W_ID;
      end
      W_ID: begin
        bus.FF_rgb_data         = {25'd0, rsp_head[6:0]};
        bus.FF_rgb_writerequest = !bus.FF_rgb_almostfull;
        if (!bus.FF_rgb_almostfull) begin
          id_wr    = 1'b1;
          wstate_d = ((rsp_cnt_q > CW'(1)) || rsp_push) ? W_DATA : W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      istate_q  <= I_IDLE;
      wstate_q  <= W_IDLE;
      credit_q  <= '0;
      addr_q    <= 32'd0;
      err_q     <= 1'b0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      rsp_cnt_q <= '0;
    end else begin
      istate_q  <= istate_d;
      wstate_q  <= wstate_d;
      credit_q  <= credit_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      tag_cnt_q <= tag_cnt_d;
      rsp_wr_q  <= rsp_wr_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  // Storage arrays are qualified by the counters, so they need no reset.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
    rsp_mem_q <= rsp_mem_d;
  end

  assign busy           = (credit_q != '0) || (istate_q != I_IDLE);
  assign err_unexpected = err_q;

`ifdef TEXFETCH_PERF_EN
  logic [31:0] perf_req_q,   perf_req_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // A non-empty, enabled FIFO that is not popped is blocked by credit or FSM.
  always_comb begin
    perf_req_d   = perf_req_q + 32'(pop);
    perf_stall_d = perf_stall_q + 32'(enable && !bus.FF_texture_empty && !pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_req_q   <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_req_q   <= perf_req_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_req_count   = perf_req_q;
  assign perf_stall_count = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_texture_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_texture_fetch_ctrl
//  Brief    : Directed, table-driven bench for texture_fetch_ctrl with
//             request-FIFO, memory and RGB-FIFO models.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_texture_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] tex_base_addr = 32'd0;
  logic        busy;
  logic        err_unexpected;
`ifdef TEXFETCH_PERF_EN
  logic [31:0] perf_req_count;
  logic [31:0] perf_stall_count;
`endif

  texture_fetch_ctrl_if tif();

  texture_fetch_ctrl #(.MAX_OUTSTANDING(4), .ADDR_SHIFT(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .tex_base_addr    (tex_base_addr),
    .bus              (tif),
    .busy             (busy),
    .err_unexpected   (err_unexpected)
`ifdef TEXFETCH_PERF_EN
    ,
    .perf_req_count   (perf_req_count),
    .perf_stall_count (perf_stall_count)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] req_tab  [64];
  logic [31:0] data_tab [64];
  logic [31:0] rgb_log  [256];
  int req_wr = 0, req_rd = 0;
  int ret_allow = 0, n_ret = 0;
  int inject_req = 0, inject_done = 0;
  int rgb_n = 0, n_pops = 0, n_acc = 0;
  logic        af = 1'b0, wreq = 1'b0, rdv = 1'b0;
  logic [31:0] rdata = 32'd0;

  assign tif.FF_texture_empty  = (req_wr == req_rd);
  assign tif.FF_texture_q      = req_tab[req_rd & 63];
  assign tif.FF_rgb_almostfull = af;
  assign tif.avm_waitrequest   = wreq;
  assign tif.avm_readdatavalid = rdv;
  assign tif.avm_readdata      = rdata;

  // Environment model: sample handshakes at the edge, update 1 ns later.
  always @(posedge clk) begin
    logic        s_pop, s_acc, s_wr;
    logic [31:0] s_d;
    s_pop = tif.FF_texture_readrequest;
    s_acc = tif.avm_read && !tif.avm_waitrequest;
    s_wr  = tif.FF_rgb_writerequest;
    s_d   = tif.FF_rgb_data;
    #1;
    if (s_pop && req_rd != req_wr) begin req_rd++; n_pops++; end
    if (s_acc) n_acc++;
    if (s_wr) begin rgb_log[rgb_n & 255] = s_d; rgb_n++; end
    if (inject_done < inject_req) begin
      rdv = 1'b1; rdata = 32'h0BAD_0BAD; inject_done++;
    end else if (n_ret < n_acc && n_ret < ret_allow) begin
      rdv = 1'b1; rdata = data_tab[n_ret & 63]; n_ret++;
    end else begin
      rdv = 1'b0; rdata = 32'd0;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_req(input logic [31:0] w);
    req_tab[req_wr & 63] = w;
    req_wr++;
  endtask

  task automatic wait_rgb(input int target, input string name);
    int k = 0;
    while (rgb_n < target && k < 200) begin @(negedge clk); k++; end
    check(name, rgb_n, target);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || req_wr != req_rd) && k < 200) begin @(negedge clk); k++; end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] q;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] id;
  } vec_t;

  vec_t vec [4];

  initial begin
    int r0, a0, p0, b, k;
    vec[0] = '{32'h1000_0000, 32'h0500_0010, 32'hAABB_CCDD, 32'h1000_0040, 32'h05};
    vec[1] = '{32'hFFFF_FFF0, 32'h7F00_0008, 32'h1234_5678, 32'h0000_0010, 32'h7F};
    vec[2] = '{32'h0000_0000, 32'h2AFF_FFFF, 32'hDEAD_BEEF, 32'h03FF_FFFC, 32'h2A};
    vec[3] = '{32'h8000_0004, 32'h0112_3456, 32'h0000_0000, 32'h8048_D15C, 32'h01};

    cyc(2);
    check("rst_rreq",  {31'd0, tif.FF_texture_readrequest}, 0);
    check("rst_read",  {31'd0, tif.avm_read}, 0);
    check("rst_addr",  tif.avm_address, 0);
    check("rst_wreq",  {31'd0, tif.FF_rgb_writerequest}, 0);
    check("rst_data",  tif.FF_rgb_data, 0);
    check("rst_busy",  {31'd0, busy}, 0);
    check("rst_err",   {31'd0, err_unexpected}, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    cyc(2);

    // Single-request transactions from the vector table.
    for (int i = 0; i < 4; i++) begin
      r0 = rgb_n;
      tex_base_addr = vec[i].base;
      data_tab[n_ret & 63] = vec[i].data;
      ret_allow = n_ret + 1;
      push_req(vec[i].q);
      #1;
      check($sformatf("v%0d_pop", i), {31'd0, tif.FF_texture_readrequest}, 1);
      @(negedge clk);
      check($sformatf("v%0d_read", i), {31'd0, tif.avm_read}, 1);
      check($sformatf("v%0d_addr", i), tif.avm_address, vec[i].addr);
      wait_rgb(r0 + 2, $sformatf("v%0d_nwr", i));
      check($sformatf("v%0d_data", i), rgb_log[r0 & 255], vec[i].data);
      check($sformatf("v%0d_id", i), rgb_log[(r0 + 1) & 255], vec[i].id);
      wait_idle($sformatf("v%0d_idle", i));
    end

    // Saturation: memory withholds data, only 4 requests may be popped.
    r0 = rgb_n; p0 = n_pops; a0 = n_acc; b = n_ret;
    ret_allow = b;
    tex_base_addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      data_tab[(b + i) & 63] = 32'hD000_0000 + i;
      push_req({1'b0, 7'(16 + i), 24'(i * 4)});
    end
    cyc(30);
    check("sat_pops",  n_pops - p0, 4);
    check("sat_rreq",  {31'd0, tif.FF_texture_readrequest}, 0);
    check("sat_reads", n_acc - a0, 4);
    check("sat_busy",  {31'd0, busy}, 1);
    ret_allow = b + 1;
    cyc(30);
    check("sat_pops1", n_pops - p0, 5);
    check("sat_wr1",   rgb_n - r0, 2);
    ret_allow = b + 6;
    wait_rgb(r0 + 12, "sat_nwr");
    for (int i = 0; i < 6; i++) begin
      check($sformatf("sat_d%0d", i), rgb_log[(r0 + 2 * i) & 255], 32'hD000_0000 + i);
      check($sformatf("sat_i%0d", i), rgb_log[(r0 + 2 * i + 1) & 255], 32'h10 + i);
    end
    wait_idle("sat_idle");

    // Waitrequest held for 5 cycles.
    r0 = rgb_n; a0 = n_acc;
    wreq = 1'b1;
    tex_base_addr = 32'h0000_1000;
    data_tab[n_ret & 63] = 32'hCAFE_F00D;
    ret_allow = n_ret + 1;
    push_req(32'h0300_0100);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wr_read%0d", i), {31'd0, tif.avm_read}, 1);
      check($sformatf("wr_addr%0d", i), tif.avm_address, 32'h0000_1400);
      @(negedge clk);
    end
    check("wr_noacc", n_acc - a0, 0);
    wreq = 1'b0;
    wait_rgb(r0 + 2, "wr_nwr");
    check("wr_acc", n_acc - a0, 1);
    check("wr_data", rgb_log[r0 & 255], 32'hCAFE_F00D);
    check("wr_id", rgb_log[(r0 + 1) & 255], 32'h03);
    wait_idle("wr_idle");

    // Backpressure between the first data word and its ID word.
    r0 = rgb_n; a0 = n_acc; b = n_ret;
    ret_allow = b;
    tex_base_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      data_tab[(b + i) & 63] = 32'hB0B0_0000 + i;
      push_req({1'b0, 7'(32 + i), 24'(i)});
    end
    k = 0;
    while (n_acc - a0 < 3 && k < 100) begin @(negedge clk); k++; end
    check("bp_reads", n_acc - a0, 3);
    ret_allow = b + 3;
    k = 0;
    while (rgb_n < r0 + 1 && k < 100) begin @(negedge clk); k++; end
    af = 1'b1;
    check("bp_first", rgb_n - r0, 1);
    #1;
    check("bp_wreq0", {31'd0, tif.FF_rgb_writerequest}, 0);
    check("bp_hold0", tif.FF_rgb_data, 32'h20);
    cyc(5);
    check("bp_nowr", rgb_n - r0, 1);
    check("bp_hold1", tif.FF_rgb_data, 32'h20);
    af = 1'b0;
    wait_rgb(r0 + 6, "bp_nwr");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_d%0d", i), rgb_log[(r0 + 2 * i) & 255], 32'hB0B0_0000 + i);
      check($sformatf("bp_i%0d", i), rgb_log[(r0 + 2 * i + 1) & 255], 32'h20 + i);
    end
    wait_idle("bp_idle");

    // Unexpected readdatavalid.
    r0 = rgb_n;
    check("err_pre", {31'd0, err_unexpected}, 0);
    inject_req++;
    cyc(3);
    check("err_set", {31'd0, err_unexpected}, 1);
    cyc(10);
    check("err_sticky", {31'd0, err_unexpected}, 1);
    check("err_nowr", rgb_n - r0, 0);
    check("err_busy", {31'd0, busy}, 0);
`ifdef TEXFETCH_PERF_EN
    check("perf_req", perf_req_count, n_pops);
`endif

    // Asynchronous reset while a read is stalled.
    ret_allow = n_ret;
    wreq = 1'b1;
    push_req(32'h0400_0001);
    cyc(1);
    check("mr_read", {31'd0, tif.avm_read}, 1);
    check("mr_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("mr_read0", {31'd0, tif.avm_read}, 0);
    check("mr_addr0", tif.avm_address, 0);
    check("mr_busy0", {31'd0, busy}, 0);
    check("mr_err0", {31'd0, err_unexpected}, 0);
    cyc(2);
    wreq  = 1'b0;
    rst_n = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/texture_fetch_ctrl.md
Name: texture_fetch_ctrl

Overview:
- Back-end sequencer for the texture path.
- Pops request words (core_id + texel address) from FIFO_TEXTURE and issues pipelined Avalon-MM reads to texture memory, with up to MAX_OUTSTANDING reads in flight.
- Writes each result into FIFO_RGB as two words, data first then core ID, in request order.
- Sits between the two texture FIFOs and the memory interconnect, opposite the core-side texture arbiter.

Parameters:
MAX_OUTSTANDING, 4, max requests popped but not yet fully written to FIFO_RGB (power of two, 2..16)
ADDR_SHIFT, 2, log2 bytes per texel; byte offset = texel address << ADDR_SHIFT

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  permits popping new requests
tex_base_addr  in  32  texture region byte base address (sampled at issue)
FF_texture_empty  in  1  request FIFO empty
FF_texture_readrequest  out  1  pop request FIFO (show-ahead; q valid while !empty)
FF_texture_q  in  32  [31]=0, [30:24]=core_id, [23:0]=texel address
FF_rgb_almostfull  in  1  response FIFO cannot accept a write this cycle
FF_rgb_writerequest  out  1  response FIFO write strobe
FF_rgb_data  out  32  texel data, or {25'b0, core_id}
avm_address  out  32  Avalon read byte address
avm_read  out  1  Avalon read command
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data valid, in issue order
busy  out  1  credit count != 0 or issue FSM != IDLE
err_unexpected  out  1  sticky; readdatavalid seen with no outstanding tag

Behaviour:
- Reset: all outputs 0; both FSMs idle; credit count 0; tag FIFO and response buffer empty; err_unexpected 0.
- Credit counter:
  - Increments on each pop; decrements on each ID-word write.
  - Simultaneous increment and decrement: no change.
  - Pop is allowed only when count < MAX_OUTSTANDING, so the internal buffers can never overflow.
- Issue FSM:
  - I_IDLE: if enable && !FF_texture_empty && credit available:
    - FF_texture_readrequest=1 for one cycle.
    - Latch address/core_id; push core_id into tag FIFO.
    - Go to I_ISSUE.
  - I_ISSUE:
    - avm_read=1, avm_address = tex_base_addr + (addr << ADDR_SHIFT), truncated mod 2^32.
    - Address and read are held stable while avm_waitrequest=1.
    - On !avm_waitrequest, go to I_IDLE.
  - Timing: pop in cycle N gives avm_read in N+1. Peak rate is one read per 2 cycles.
- Response capture:
  - On avm_readdatavalid, pop the tag-FIFO head and push {readdata, core_id} into the response buffer (depth MAX_OUTSTANDING).
  - A response returning in the same cycle as a tag push for a new request is legal; the FIFO ordering is preserved.
  - readdatavalid with an empty tag FIFO: data dropped, err_unexpected set until reset.
- Writer FSM:
  - W_IDLE: if response buffer non-empty, go to W_DATA.
  - W_DATA: FF_rgb_writerequest = !FF_rgb_almostfull, FF_rgb_data = head data. On write, go to W_ID.
  - W_ID: FF_rgb_writerequest = !FF_rgb_almostfull, FF_rgb_data = {25'b0, head core_id}. On write:
    - Pop response buffer and decrement credit.
    - Go to W_DATA if another entry is buffered, else W_IDLE.
  - While almostfull, state and FF_rgb_data hold. The data and ID words of one response are never interleaved with another response.
  - FF_rgb_data = 0 in W_IDLE.
- enable deassert:
  - No new pops.
  - A read in I_ISSUE and all in-flight responses still complete and drain.
- Reset mid-operation: all state discarded immediately. The memory interconnect shares rst_n, so no late readdatavalid is expected.

Optional Feature:
- Macro TEXFETCH_PERF_EN.
- Defined: adds outputs perf_req_count[31:0] and perf_stall_count[31:0].
  - perf_req_count: +1 per pop.
  - perf_stall_count: +1 per cycle where the request FIFO is non-empty and enable=1, but a pop is blocked by credit exhaustion or the issue FSM being busy.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; no other behavioural change.

Test Plan:
- Single request: q=0x05_000010, base 0x1000_0000, no stalls.
  - Expect avm_address=0x1000_0040 one cycle after pop.
  - Expect readdata 0xAABBCCDD followed by FIFO_RGB writes 0xAABBCCDD then 0x00000005.
  - busy returns to 0.
- Saturation: 6 queued requests, memory never returns data, MAX_OUTSTANDING=4.
  - Exactly 4 pops, then FF_texture_readrequest stays 0.
  - Returning one response and writing both words allows exactly one more pop.
- Waitrequest stall: avm_waitrequest=1 for 5 cycles.
  - avm_read and avm_address held constant.
  - Exactly one read accepted.
- Backpressure: FF_rgb_almostfull=1 between the data word and the ID word.
  - No writes while asserted; ID word follows once deasserted.
  - Order across 3 responses is data0, id0, data1, id1, data2, id2.
- Wrap: base 0xFFFF_FFF0, addr 0x000008 -> avm_address=0x0000_0010.
- Error: readdatavalid with nothing outstanding -> err_unexpected=1 and stays 1. With TEXFETCH_PERF_EN defined, perf_req_count matches the number of pops.
